// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-read arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER,
        RELEASE
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int ADDR_W       = 9;

endpackage

// File: rtl/sd_sector_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: grants the first set request after position i_last, wrapping.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_index
);

    logic [IDX_W-1:0] w_sel;

    // Scan from the farthest slot to the nearest so the nearest hit wins.
    always_comb begin
        o_gnt   = '0;
        o_index = '0;
        w_sel   = '0;
        for (int k = N; k >= 1; k--) begin
            w_sel = IDX_W'((int'(i_last) + k) % N);
            if (i_req[w_sel]) begin
                o_gnt        = '0;
                o_gnt[w_sel] = 1'b1;
                o_index      = w_sel;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the single sd_fat_reader sector port between NREQ requesters with
// round-robin grants, per-requester byte routing and a start-to-busy watchdog.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int TIMEOUT_W = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NREQ-1:0]      i_req,
    input  logic [32*NREQ-1:0]   i_req_lba,
    output logic [NREQ-1:0]      o_ack,
    output logic [NREQ-1:0]      o_done,
    output logic [NREQ-1:0]      o_err,
    output logic [NREQ-1:0]      o_buf_strobe,
    output logic [ADDR_W-1:0]    o_buf_addr,
    output logic [7:0]           o_buf_data,
    output logic                 o_rstart,
    output logic [31:0]          o_rsector,
    input  logic                 i_rbusy,
    input  logic                 i_rdone,
    input  logic                 i_outen,
    input  logic [ADDR_W-1:0]    i_outaddr,
    input  logic [7:0]           i_outbyte,
    output logic                 o_active
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_grant;
    logic [NREQ-1:0]      r_gnt_oh;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic                 r_rstart;
    logic [31:0]          r_rsector;
    logic [NREQ-1:0]      r_ack;
    logic [NREQ-1:0]      r_done;
    logic [NREQ-1:0]      r_err;
    logic                 r_rbusy_q;

    logic [NREQ-1:0]      w_gnt;
    logic [IDX_W-1:0]     w_idx;
    logic [31:0]          w_lba;
    logic [TIMEOUT_W-1:0] w_wdog_inc;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_index (w_idx)
    );

    always_comb begin
        w_lba      = i_req_lba[32*int'(w_idx) +: 32];
        w_wdog_inc = r_wdog + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= IDLE;
            r_last    <= IDX_W'(NREQ - 1);
            r_grant   <= '0;
            r_gnt_oh  <= '0;
            r_wdog    <= '0;
            r_rstart  <= 1'b0;
            r_rsector <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_rbusy_q <= 1'b0;
        end else begin
            r_done    <= '0;
            r_err     <= '0;
            r_rbusy_q <= i_rbusy;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_grant   <= w_idx;
                        r_gnt_oh  <= w_gnt;
                        r_rsector <= w_lba;
                        r_wdog    <= '0;
                        r_rstart  <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (i_rbusy) begin
                        r_wdog   <= '0;
                        r_rstart <= 1'b0;
                        r_ack    <= r_gnt_oh;
                        r_state  <= XFER;
                    end else begin
                        r_wdog <= w_wdog_inc;
                        // Card never went busy: give the port back rather than hang.
                        if (&w_wdog_inc) begin
                            r_err    <= r_gnt_oh;
                            r_rstart <= 1'b0;
                            r_state  <= RELEASE;
                        end
                    end
                end
                XFER: begin
                    // Busy falling without rdone is treated as completion too.
                    if (i_rdone || (r_rbusy_q && !i_rbusy)) begin
                        r_done  <= r_gnt_oh;
                        r_ack   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_last <= r_grant;
                    if (!i_req[r_grant]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_buf_strobe = (r_state == XFER && i_outen) ? r_gnt_oh : '0;
        o_buf_addr   = i_outaddr;
        o_buf_data   = i_outbyte;
        o_ack        = r_ack;
        o_done       = r_done;
        o_err        = r_err;
        o_rstart     = r_rstart;
        o_rsector    = r_rsector;
        o_active     = (r_state != IDLE);
    end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Self-checking bench for sd_sector_arbiter: reader model, requester model and grant scoreboard.
module tb_sd_sector_arbiter;
    import sd_arb_pkg::*;

    localparam int NREQ      = 3;
    localparam int TIMEOUT_W = 4;

    typedef struct {
        int          req;
        logic [31:0] lba;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] req_lba;
    logic [31:0]        lba [NREQ];
    logic               rbusy, rdone, outen;
    logic [8:0]         outaddr;
    logic [7:0]         outbyte;

    logic [NREQ-1:0]    o_ack, o_done, o_err, o_buf_strobe;
    logic [8:0]         o_buf_addr;
    logic [7:0]         o_buf_data;
    logic               o_rstart, o_active;
    logic [31:0]        o_rsector;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb[$];
    int   cur = -1;
    logic [31:0] cur_lba = '0;
    int   str_cnt [NREQ];
    int   bad_data = 0;
    int   ev_cnt = 0, done_cnt = 0, err_cnt = 0;
    int   rs_len = 0, rs_len_last = 0;
    logic rs_prev = 1'b0;
    logic [NREQ-1:0] fin = '0;

    int   rd_ph = 0, rd_cnt = 0;
    logic rd_en = 1'b1, idle_noise = 1'b0, hold = 1'b0;
    int   quota [NREQ];
    int   rearm [NREQ];

    sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT_W(TIMEOUT_W)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req        (req),
        .i_req_lba    (req_lba),
        .o_ack        (o_ack),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_buf_strobe (o_buf_strobe),
        .o_buf_addr   (o_buf_addr),
        .o_buf_data   (o_buf_data),
        .o_rstart     (o_rstart),
        .o_rsector    (o_rsector),
        .i_rbusy      (rbusy),
        .i_rdone      (rdone),
        .i_outen      (outen),
        .i_outaddr    (outaddr),
        .i_outbyte    (outbyte),
        .o_active     (o_active)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_lba = '0;
        for (int i = 0; i < NREQ; i++) req_lba[32*i +: 32] = lba[i];
    end

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = '0;
        if (i >= 0 && i < NREQ) oh[i] = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int r, input logic [31:0] l);
        exp_t e;
        e.req = r;
        e.lba = l;
        sb.push_back(e);
    endtask

    task automatic wait_ev(input int target, input int budget, input string tag);
        int c = 0;
        while (ev_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(ev_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (o_active && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(o_active), 0);
    endtask

    // sd_fat_reader model: busy 5 cycles after rstart, 512 bytes with data = addr[7:0], then rdone.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            rd_ph = 0; rd_cnt = 0; rbusy = 0; rdone = 0; outen = 0; outaddr = '0; outbyte = '0;
        end else begin
            case (rd_ph)
                0: begin
                    rbusy = 0; rdone = 0; outen = idle_noise; outaddr = 9'h0AA; outbyte = 8'h55;
                    if (o_rstart && rd_en) begin rd_ph = 1; rd_cnt = 0; end
                end
                1: begin
                    rd_cnt++;
                    outen = (rd_cnt < 5); outaddr = 9'h1FF; outbyte = 8'hEE;
                    if (rd_cnt == 5) begin rbusy = 1; rd_ph = 2; rd_cnt = 0; end
                end
                2: begin
                    outen = 1; outaddr = rd_cnt[8:0]; outbyte = rd_cnt[7:0];
                    rd_cnt++;
                    if (rd_cnt == SECTOR_BYTES) rd_ph = 3;
                end
                3: begin outen = 0; rdone = 1; rd_ph = 4; end
                default: begin rdone = 0; rbusy = 0; rd_ph = 0; end
            endcase
        end
    end

    // Requester model: drop on done/err (unless holding), re-request 2 cycles later while quota remains.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (fin[i]) begin
                fin[i] = 1'b0;
                if (!hold) begin
                    req[i] = 1'b0;
                    if (quota[i] > 0) begin quota[i]--; rearm[i] = 2; end
                end
            end else if (rearm[i] > 0) begin
                rearm[i]--;
                if (rearm[i] == 0) req[i] = 1'b1;
            end
        end
    end

    // Monitor: pops the expected grant on each rstart rise, checks routing and completion.
    initial begin
        exp_t e;
        int   tot, own;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cur = -1; rs_prev = 1'b0; rs_len = 0; bad_data = 0; fin = '0;
                for (int i = 0; i < NREQ; i++) str_cnt[i] = 0;
            end else begin
                if (o_rstart && !rs_prev) begin
                    for (int i = 0; i < NREQ; i++) str_cnt[i] = 0;
                    bad_data = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_rstart", 1, 0);
                        cur = -1;
                    end else begin
                        e = sb.pop_front();
                        cur = e.req;
                        cur_lba = e.lba;
                        check("rsector", o_rsector, e.lba);
                    end
                end
                if (o_rstart) rs_len++;
                else if (rs_prev) begin rs_len_last = rs_len; rs_len = 0; end
                rs_prev = o_rstart;
                for (int i = 0; i < NREQ; i++) if (o_buf_strobe[i]) str_cnt[i]++;
                if (o_buf_strobe != 0 && o_buf_data != o_buf_addr[7:0]) bad_data++;
                if (rd_ph == 2 && rd_cnt == 3) check("ack", o_ack, oh(cur));
                if (o_done != 0 || o_err != 0) begin
                    tot = 0;
                    for (int i = 0; i < NREQ; i++) tot += str_cnt[i];
                    own = (cur >= 0) ? str_cnt[cur] : 0;
                    check("rsector_hold", o_rsector, cur_lba);
                    if (o_done != 0) begin
                        check("done", o_done, oh(cur));
                        check("strobes_own", own, SECTOR_BYTES);
                        check("strobes_other", tot - own, 0);
                        check("byte_data", bad_data, 0);
                        done_cnt++;
                    end else begin
                        check("err", o_err, oh(cur));
                        check("err_strobes", tot, 0);
                        err_cnt++;
                    end
                    if (cur >= 0) fin[cur] = 1'b1;
                    ev_cnt++;
                end
            end
        end
    end

    initial begin
        int base, base_d, base_e, bad, c;
        rstn = 1'b1; req = '0;
        for (int i = 0; i < NREQ; i++) begin lba[i] = '0; quota[i] = 0; rearm[i] = 0; end
        #1 rstn = 1'b0;
        #3;
        check("rst_rstart", o_rstart, 0);
        check("rst_ack", o_ack, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_strobe", o_buf_strobe, 0);
        check("rst_rsector", o_rsector, 0);
        check("rst_active", o_active, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        idle_noise = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_strobe", o_buf_strobe, 0);
        check("idle_active", o_active, 0);
        idle_noise = 1'b0;

        // Round robin: all three request together, each twice.
        for (int i = 0; i < NREQ; i++) begin lba[i] = 32'hA000_0000 + 32'(i) * 32'h11; quota[i] = 1; end
        for (int s = 0; s < 2 * NREQ; s++) push_exp(s % NREQ, 32'hA000_0000 + 32'(s % NREQ) * 32'h11);
        @(posedge clk); #1 req = '1;
        wait_ev(2 * NREQ, 2 * NREQ * 700, "rr_six_sectors");
        wait_idle(20, "rr_idle");

        // Single request: latency and rstart width.
        lba[0] = 32'h0000_0123;
        push_exp(0, 32'h0000_0123);
        base = ev_cnt;
        @(posedge clk); #1 req[0] = 1'b1;
        @(negedge clk); check("rstart_pre", o_rstart, 0);
        @(negedge clk); check("rstart_lat", o_rstart, 1);
        check("rsector_lat", o_rsector, 32'h0000_0123);
        wait_ev(base + 1, 700, "single_done");
        check("rstart_len", rs_len_last, 6);
        wait_idle(10, "single_idle");

        // Watchdog: reader never goes busy.
        rd_en = 1'b0; hold = 1'b1;
        lba[1] = 32'hBEEF_0001;
        push_exp(1, 32'hBEEF_0001);
        base = ev_cnt; base_d = done_cnt; base_e = err_cnt;
        @(posedge clk); #1 req[1] = 1'b1;
        wait_ev(base + 1, 100, "wdog_err");
        check("wdog_rstart_len", rs_len_last, 15);
        check("wdog_no_done", done_cnt - base_d, 0);
        check("wdog_err_cnt", err_cnt - base_e, 1);
        repeat (3) @(negedge clk);
        check("wdog_hold_release", o_active, 1);
        req[1] = 1'b0; hold = 1'b0;
        wait_idle(5, "wdog_idle");
        rd_en = 1'b1;

        // Request withdrawn mid-transfer; lba change after grant must not matter.
        lba[2] = 32'hC0DE_0002;
        push_exp(2, 32'hC0DE_0002);
        base = ev_cnt;
        @(posedge clk); #1 req[2] = 1'b1;
        c = 0;
        while (!(rd_ph == 2 && rd_cnt >= 10) && c < 100) begin @(negedge clk); c++; end
        check("wd_reach_xfer", 32'(rd_ph == 2), 1);
        req[2] = 1'b0; lba[2] = 32'hDEAD_DEAD;
        wait_ev(base + 1, 700, "wd_done");
        wait_idle(10, "wd_idle");

        // Held request is never re-served.
        hold = 1'b1;
        lba[0] = 32'h0000_0777;
        push_exp(0, 32'h0000_0777);
        base = ev_cnt;
        @(posedge clk); #1 req[0] = 1'b1;
        wait_ev(base + 1, 700, "held_done");
        bad = 0;
        repeat (20) begin @(negedge clk); if (o_rstart) bad++; end
        check("held_no_rstart", bad, 0);
        check("held_in_release", o_active, 1);
        req[0] = 1'b0; hold = 1'b0;
        wait_idle(5, "held_idle");

        // Reset in the middle of a transfer.
        lba[0] = 32'h0000_0500; lba[1] = 32'h0000_0501;
        push_exp(0, 32'h0000_0500);
        @(posedge clk); #1 req[0] = 1'b1;
        c = 0;
        while (!(rd_ph == 2 && rd_cnt >= 100) && c < 200) begin @(negedge clk); c++; end
        check("mid_reach_byte100", 32'(rd_ph == 2 && rd_cnt >= 100), 1);
        req[1] = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rstart", o_rstart, 0);
        check("mid_rst_ack", o_ack, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_strobe", o_buf_strobe, 0);
        check("mid_rst_rsector", o_rsector, 0);
        check("mid_rst_active", o_active, 0);
        push_exp(0, 32'h0000_0500);
        push_exp(1, 32'h0000_0501);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        base = ev_cnt;
        wait_ev(base + 2, 1500, "post_rst_two");
        wait_idle(10, "post_rst_idle");
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
